// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter
// Schedules the single Spartan-6 MIG port pair between the user write
// controller (p2) and the user read controller (p3). A side requests when its
// FIFO can take or give a whole burst. One burst is outstanding at a time.
// Simultaneous requests are served round-robin, and write wins the first tie.
//
// Optional feature: define DDR_ARB_TIMEOUT_EN to enable a burst watchdog.
// It forces IDLE after TIMEOUT_CYC cycles without an end pulse and sets a
// sticky timeout_err. Without the macro the FSM waits indefinitely for the
// end pulse, and timeout_err is tied low.

module ddr3_rw_arbiter #(
   parameter int BURST_BL    = 63,
   parameter int FIFO_CW     = 10,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic               sclk,
   input  logic               rst_n,
   input  logic               calib_done,
   input  logic               rd_enable,
   input  logic [FIFO_CW-1:0] wfifo_count,
   input  logic [FIFO_CW-1:0] rfifo_space,
   output logic               wr_start,
   output logic [5:0]         wr_cmd_bl,
   input  logic               wr_end,
   output logic               rd_start,
   output logic [5:0]         rd_cmd_bl,
   input  logic               rd_end,
   output logic               busy,
   output logic               last_grant,
   output logic               timeout_err
);

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;

   // Words per burst, formed at FIFO width so that 63+1 stays 64.
   localparam logic [FIFO_CW-1:0] BURST_WORDS = FIFO_CW'(BURST_BL) + FIFO_CW'(1);
   localparam logic [5:0]         CMD_BL      = 6'(BURST_BL);

   state_t state;
   logic   wr_req;
   logic   rd_req;
   logic   grant_wr;
   logic   grant_rd;
   logic   burst_done;
   logic   wd_expire;

`ifdef DDR_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] wd_cnt;
   assign wd_expire = (wd_cnt == WD_LAST);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
   assign wd_expire          = 1'b0;
   assign timeout_err        = 1'b0;
`endif

   // Request terms, the round-robin grant decision and the end pulse of the granted side.
   // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
   always_comb begin
      wr_req     = (wfifo_count >= BURST_WORDS);
      rd_req     = rd_enable & (rfifo_space >= BURST_WORDS);
      grant_wr   = calib_done & wr_req & (~rd_req | last_grant);
      grant_rd   = calib_done & rd_req & (~wr_req | ~last_grant);
      burst_done = 1'b0;
      if (state == WR) burst_done = wr_end;
      if (state == RD) burst_done = rd_end;
   end

   // Arbiter FSM with registered start pulses, burst lengths, busy and grant history.
   // NOTE: state is updated only with non-blocking assignments. Every register reads the pre-edge values.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_start   <= 1'b0;
         rd_start   <= 1'b0;
         wr_cmd_bl  <= 6'd0;
         rd_cmd_bl  <= 6'd0;
         busy       <= 1'b0;
         last_grant <= 1'b1;
`ifdef DDR_ARB_TIMEOUT_EN
         wd_cnt      <= 16'd0;
         timeout_err <= 1'b0;
`endif
      end else begin
         wr_start <= 1'b0;
         rd_start <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  state      <= WR;
                  wr_start   <= 1'b1;
                  wr_cmd_bl  <= CMD_BL;
                  busy       <= 1'b1;
                  last_grant <= 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
                  wd_cnt     <= 16'd0;
`endif
               end else if (grant_rd) begin
                  state      <= RD;
                  rd_start   <= 1'b1;
                  rd_cmd_bl  <= CMD_BL;
                  busy       <= 1'b1;
                  last_grant <= 1'b1;
`ifdef DDR_ARB_TIMEOUT_EN
                  wd_cnt     <= 16'd0;
`endif
               end
            end
            WR, RD: begin
               if (burst_done || wd_expire) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  wr_cmd_bl <= 6'd0;
                  rd_cmd_bl <= 6'd0;
               end
`ifdef DDR_ARB_TIMEOUT_EN
               wd_cnt <= wd_cnt + 16'd1;
               if (!burst_done && wd_expire) timeout_err <= 1'b1;
`endif
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               wr_cmd_bl <= 6'd0;
               rd_cmd_bl <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter
// Directed bench for ddr3_rw_arbiter. A transaction-level model tracks which
// side owns the memory and what must appear on the outputs, and it is compared
// every cycle. Literal expectations pin the key timings. Define
// DDR_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYC = 16.

module tb_ddr3_rw_arbiter;

   localparam int BURST_BL    = 63;
   localparam int FIFO_CW     = 10;
   localparam int TIMEOUT_CYC = 16;
`ifdef DDR_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic               sclk = 1'b0;
   logic               rst_n = 1'b0;
   logic               calib_done = 1'b0;
   logic               rd_enable = 1'b0;
   logic [FIFO_CW-1:0] wfifo_count = '0;
   logic [FIFO_CW-1:0] rfifo_space = '0;
   logic               wr_end = 1'b0;
   logic               rd_end = 1'b0;
   logic               wr_start;
   logic [5:0]         wr_cmd_bl;
   logic               rd_start;
   logic [5:0]         rd_cmd_bl;
   logic               busy;
   logic               last_grant;
   logic               timeout_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   ddr3_rw_arbiter #(
      .BURST_BL    (BURST_BL),
      .FIFO_CW     (FIFO_CW),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .sclk        (sclk),
      .rst_n       (rst_n),
      .calib_done  (calib_done),
      .rd_enable   (rd_enable),
      .wfifo_count (wfifo_count),
      .rfifo_space (rfifo_space),
      .wr_start    (wr_start),
      .wr_cmd_bl   (wr_cmd_bl),
      .wr_end      (wr_end),
      .rd_start    (rd_start),
      .rd_cmd_bl   (rd_cmd_bl),
      .rd_end      (rd_end),
      .busy        (busy),
      .last_grant  (last_grant),
      .timeout_err (timeout_err)
   );

   always #5 sclk = ~sclk;
   always @(posedge sclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------
   // Model: owner of the memory (0 none, 1 write, 2 read), cycles spent in
   // the burst, whose turn a tie is, sticky watchdog flag and start pulses.
   // ---------------------------------------------------------------------
   int m_owner;
   int m_age;
   bit m_last_read;
   bit m_terr;
   bit m_wstart;
   bit m_rstart;

   always @(posedge sclk or negedge rst_n) begin
      bit wants_w;
      bit wants_r;
      if (!rst_n) begin
         m_owner     = 0;
         m_age       = 0;
         m_last_read = 1'b1;
         m_terr      = 1'b0;
         m_wstart    = 1'b0;
         m_rstart    = 1'b0;
      end else begin
         wants_w  = int'(wfifo_count) >= BURST_BL + 1;
         wants_r  = rd_enable && (int'(rfifo_space) >= BURST_BL + 1);
         m_wstart = 1'b0;
         m_rstart = 1'b0;
         if (m_owner == 0) begin
            if (calib_done && wants_w && (!wants_r || m_last_read)) begin
               m_owner = 1; m_wstart = 1'b1; m_last_read = 1'b0; m_age = 0;
            end else if (calib_done && wants_r) begin
               m_owner = 2; m_rstart = 1'b1; m_last_read = 1'b1; m_age = 0;
            end
         end else if ((m_owner == 1 && wr_end) || (m_owner == 2 && rd_end)) begin
            m_owner = 0;
         end else if (TO_EN && m_age == TIMEOUT_CYC - 1) begin
            m_owner = 0;
            m_terr  = 1'b1;
         end else begin
            m_age++;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge sclk) begin
      if (rst_n) begin
         check("wr_start",    wr_start,    m_wstart);
         check("rd_start",    rd_start,    m_rstart);
         check("wr_cmd_bl",   wr_cmd_bl,   (m_owner == 1) ? BURST_BL : 0);
         check("rd_cmd_bl",   rd_cmd_bl,   (m_owner == 2) ? BURST_BL : 0);
         check("busy",        busy,        m_owner != 0);
         check("last_grant",  last_grant,  m_last_read);
         check("timeout_err", timeout_err, TO_EN && m_terr);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sclk);
   endtask

   // Waits for a start pulse. Side is 1 for write, 2 for read, 0 if the budget expired.
   task automatic wait_start(output int side, input int budget);
      side = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sclk);
         if (wr_start === 1'b1) begin side = 1; return; end
         if (rd_start === 1'b1) begin side = 2; return; end
      end
      checks++;
      errors++;
      $display("FAIL start_wait no start pulse within %0d cycles (cycle %0d)", budget, cyc);
   endtask

   task automatic pulse_end(input int side);
      if (side == 1) wr_end = 1'b1;
      if (side == 2) rd_end = 1'b1;
      tick(1);
      wr_end = 1'b0;
      rd_end = 1'b0;
   endtask

   task automatic count_starts(input int n, output int seen);
      seen = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (wr_start === 1'b1 || rd_start === 1'b1) seen++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int side;
      int n;
      int seq[$];
      int tstart[$];

      // Reset values while reset is held
      tick(2);
      check("rst_busy",        busy,        0);
      check("rst_wr_start",    wr_start,    0);
      check("rst_wr_cmd_bl",   wr_cmd_bl,   0);
      check("rst_rd_cmd_bl",   rd_cmd_bl,   0);
      check("rst_last_grant",  last_grant,  1);
      check("rst_timeout_err", timeout_err, 0);
      rst_n = 1'b1;

      // Calibration low: both sides ready but nothing may start
      wfifo_count = 10'd100; rfifo_space = 10'd100; rd_enable = 1'b1;
      count_starts(50, n);
      check("calib_low_starts", n, 0);
      check("calib_low_busy", busy, 0);

      // Write only, exactly at the 64-word threshold
      rd_enable = 1'b0; rfifo_space = '0; wfifo_count = 10'd64; calib_done = 1'b1;
      tick(1);
      check("wr_first_start", wr_start, 1);
      check("wr_first_bl", wr_cmd_bl, 63);
      check("wr_first_busy", busy, 1);
      wfifo_count = '0;
      tick(70);
      check("wr_busy_hold", busy, 1);
      pulse_end(1);
      check("wr_end_busy", busy, 0);

      // Write one word short of a burst and read space ready: only a read starts
      wfifo_count = 10'd63; rfifo_space = 10'd64; rd_enable = 1'b1;
      tick(1);
      check("rd_only_start", rd_start, 1);
      check("rd_only_wr_start", wr_start, 0);
      check("rd_only_bl", rd_cmd_bl, 63);
      rd_enable = 1'b0;
      tick(5);
      pulse_end(2);
      check("rd_end_busy", busy, 0);

      // Both requesting continuously: W,R,W,R every 12 cycles
      wfifo_count = 10'd64; rfifo_space = 10'd64; rd_enable = 1'b1;
      for (int g = 0; g < 4; g++) begin
         wait_start(side, 20);
         seq.push_back(side);
         tstart.push_back(cyc);
         if (g == 3) begin wfifo_count = '0; rd_enable = 1'b0; end
         tick(10);
         pulse_end(side);
      end
      check("rr_grant0", seq[0], 1);
      check("rr_grant1", seq[1], 2);
      check("rr_grant2", seq[2], 1);
      check("rr_grant3", seq[3], 2);
      for (int i = 1; i < 4; i++) check("rr_spacing", tstart[i] - tstart[i-1], 12);

      // A spurious rd_end during a write burst is ignored
      wfifo_count = 10'd64;
      wait_start(side, 5);
      check("spur_side", side, 1);
      wfifo_count = '0;
      tick(3);
      pulse_end(2);
      check("spur_busy", busy, 1);
      tick(3);
      check("spur_busy_later", busy, 1);
      pulse_end(1);
      check("spur_done_busy", busy, 0);

      // An end pulse in the same cycle as the start completes the burst
      wfifo_count = 10'd64;
      wait_start(side, 5);
      wr_end = 1'b1; wfifo_count = '0;
      tick(1);
      wr_end = 1'b0;
      check("same_cycle_end_busy", busy, 0);

      // Calibration lost mid-burst: the burst finishes, then nothing starts
      wfifo_count = 10'd64; rfifo_space = 10'd64; rd_enable = 1'b1;
      wait_start(side, 5);
      check("calib_drop_side", side, 2);
      calib_done = 1'b0;
      tick(4);
      pulse_end(2);
      count_starts(20, n);
      check("calib_drop_starts", n, 0);
      check("calib_drop_busy", busy, 0);
      calib_done = 1'b1;
      wait_start(side, 5);
      check("calib_back_side", side, 1);
      wfifo_count = '0; rd_enable = 1'b0;
      tick(2);
      pulse_end(1);

`ifdef DDR_ARB_TIMEOUT_EN
      // Watchdog: write end withheld, the burst is abandoned after 16 cycles
      wfifo_count = 10'd64;
      wait_start(side, 5);
      check("wd_side", side, 1);
      wfifo_count = '0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick(1);
      end
      check("wd_cycles_in_wr", n, 16);
      check("wd_err_set", timeout_err, 1);
      wfifo_count = 10'd64; rfifo_space = 10'd64; rd_enable = 1'b1;
      wait_start(side, 5);
      check("wd_next_tie_read", side, 2);
      wfifo_count = '0; rd_enable = 1'b0;
      tick(2);
      pulse_end(2);
      check("wd_err_sticky", timeout_err, 1);
`endif

      // Reset asserted mid-burst returns outputs to reset values at once
      wfifo_count = 10'd64;
      wait_start(side, 5);
      wfifo_count = '0;
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_wr_cmd_bl", wr_cmd_bl, 0);
      check("mid_rst_last_grant", last_grant, 1);
      check("mid_rst_timeout_err", timeout_err, 0);
      tick(1);
      rst_n = 1'b1;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr3_rw_arbiter.md
Name: ddr3_rw_arbiter

Overview:
- Schedules the single Spartan-6 MIG (non-AXI) memory between the user write controller (port p2) and the user read controller (port p3).
- Watches write-FIFO fill level and read-FIFO free space, then issues one-cycle wr_start / rd_start pulses with burst length.
- Waits for the matching end pulse before granting again; round-robin when both sides request.
- Sits between the user FIFOs and the user_wr_ctrl / user_rd_ctrl pair.

Parameters:
- BURST_BL, 63, MIG cmd_bl value (burst = BURST_BL+1 words), 6-bit range 0..63
- FIFO_CW, 10, width of FIFO count inputs
- TIMEOUT_CYC, 4096, watchdog limit in sclk cycles (used only with the optional feature)

Ports:
- sclk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- calib_done  input  1  MIG calibration complete; no grants while low
- rd_enable  input  1  read path enabled by upstream
- wfifo_count  input  FIFO_CW  words waiting in write FIFO
- rfifo_space  input  FIFO_CW  free words in read FIFO
- wr_start  output  1  one-cycle start pulse to write controller
- wr_cmd_bl  output  6  burst length for write command
- wr_end  input  1  write burst done pulse
- rd_start  output  1  one-cycle start pulse to read controller
- rd_cmd_bl  output  6  burst length for read command
- rd_end  input  1  read burst done pulse
- busy  output  1  high while in WR or RD state
- last_grant  output  1  0 = last grant was write, 1 = last grant was read
- timeout_err  output  1  sticky watchdog error (optional feature)

Behaviour:
- Reset values (async on rst_n low): state IDLE, wr_start=0, rd_start=0, wr_cmd_bl=0, rd_cmd_bl=0, busy=0, last_grant=1 (write wins first tie), timeout_err=0.
- Request terms:
  - wr_req = wfifo_count >= BURST_BL+1
  - rd_req = rd_enable & (rfifo_space >= BURST_BL+1)
  - Compare at FIFO_CW width with BURST_BL zero-extended; BURST_BL+1 = 64 must not truncate.
- FSM states: IDLE, WR, RD.
  - IDLE: if calib_done=0, stay. Otherwise:
    - wr_req only -> WR
    - rd_req only -> RD
    - both -> WR if last_grant=1, else RD
    - neither -> stay
  - Entering WR: registered wr_start=1 for exactly one cycle, wr_cmd_bl=BURST_BL, last_grant<=0, busy<=1. Request sampled at cycle N gives start at N+1.
  - Entering RD: same behaviour with rd_start / rd_cmd_bl, last_grant<=1.
  - WR: wait for wr_end; on wr_end at cycle M go to IDLE at M+1, busy=0 at M+1. Earliest next start is M+2.
  - RD: same with rd_end.
- wr_cmd_bl / rd_cmd_bl hold BURST_BL while busy in that state; return to 0 in IDLE.
- End pulses received in IDLE, or for the non-granted side, are ignored. No state change.
- wr_end arriving in the same cycle as wr_start is accepted as completion.
- wr_start and rd_start are never high in the same cycle. Only one burst is outstanding at a time.
- calib_done falling while in WR/RD: the current burst completes normally, then the FSM holds in IDLE.
- Reset asserted mid-burst: immediate return to reset values. The controllers are reset by the same rst_n.

Optional Feature:
- Macro: DDR_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to WR/RD and increments each cycle in WR/RD.
  - If it reaches TIMEOUT_CYC-1 without the end pulse, the FSM forces IDLE next cycle and sets timeout_err=1 (sticky until reset).
  - last_grant is kept, so the other side gets the next tie.
- Without the macro: no counter, the FSM waits indefinitely, timeout_err tied 0.

Test Plan:
- Reset, then calib_done=0 with wfifo_count=100, rfifo_space=100 -> no start pulses for 50 cycles, busy=0.
- calib_done=1, wfifo_count=64, rd_enable=0 -> wr_start pulses 1 cycle after the request is sampled, wr_cmd_bl=63, busy=1. wr_end 70 cycles later -> busy=0 the next cycle.
- wfifo_count=63 (below threshold), rfifo_space=64, rd_enable=1 -> only rd_start issued, rd_cmd_bl=63.
- Both requests held continuously, each end returned 10 cycles after start -> grants alternate W,R,W,R. First grant is write. Starts are never simultaneous. Start-to-start spacing is 12 cycles.
- Spurious rd_end during a WR burst -> ignored, FSM stays in WR until wr_end arrives.
- DDR_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, wr_end withheld -> IDLE after 16 cycles in WR, timeout_err=1 and held. The next tie grants read.
